// File: rtl/alu_multicycle.sv
// Multicycle ALU: single-cycle arithmetic/logic/compare/branch, iterative MUL and DIV over WIDTH CALC cycles.
// start is only accepted in IDLE; define ALU_MULTICYCLE_HIRES_EN to expose result_hi (upper product / remainder).
module alu_multicycle #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       alu_control,
   input  logic [5:0]       func,
   input  logic [WIDTH-1:0] data_a,
   input  logic [WIDTH-1:0] data_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [2:0]       flag,
`ifdef ALU_MULTICYCLE_HIRES_EN
   output logic [WIDTH-1:0] result_hi,
`endif
   output logic             branch
);

   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [2:0] OP_ADDI = 3'b000, OP_SUBI = 3'b001, OP_TYPER = 3'b010, OP_ANDI = 3'b011,
                          OP_ORI  = 3'b100, OP_BRFL = 3'b101, OP_CMP   = 3'b110;
   localparam logic [5:0] FN_ADD = 6'b100000, FN_SUB = 6'b100010, FN_MUL = 6'b000010, FN_DIV = 6'b000001,
                          FN_AND = 6'b100100, FN_OR  = 6'b100101, FN_NOT = 6'b100111;
   localparam logic [2:0] FL_NONE = 3'b000, FL_EQUAL = 3'b001, FL_EXC = 3'b010, FL_OVF = 3'b011,
                          FL_UNF  = 3'b100, FL_ABOVE = 3'b101;

   typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             mul_q, mul_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [2:0]       flag_q, flag_d;
   logic             branch_q, branch_d;
`ifdef ALU_MULTICYCLE_HIRES_EN
   logic [WIDTH-1:0] rhi_q, rhi_d;
`endif

   logic [WIDTH:0]   add_sum, mul_sum, div_shift, div_trial;
   logic [WIDTH-1:0] step_hi, step_lo;
   logic             is_mul, is_div;

   assign is_mul    = (alu_control == OP_TYPER) && (func == FN_MUL);
   assign is_div    = (alu_control == OP_TYPER) && (func == FN_DIV);
   assign add_sum   = {1'b0, data_a} + {1'b0, data_b};
   assign mul_sum   = {1'b0, hi_q} + {1'b0, b_q};
   assign div_shift = {hi_q, lo_q[WIDTH-1]};
   assign div_trial = div_shift - {1'b0, b_q};

   // hi:lo is the product (multiplier consumed from lo) or remainder:quotient (dividend shifted out of lo).
   always_comb begin
      step_hi = hi_q;
      step_lo = lo_q;
      if (mul_q) begin
         if (lo_q[0]) begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
         end else begin
            step_hi = {1'b0, hi_q[WIDTH-1:1]};
            step_lo = {hi_q[0], lo_q[WIDTH-1:1]};
         end
      end else if (!div_trial[WIDTH]) begin
         step_hi = div_trial[WIDTH-1:0];
         step_lo = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
         step_hi = div_shift[WIDTH-1:0];
         step_lo = {lo_q[WIDTH-2:0], 1'b0};
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      mul_d    = mul_q;
      b_d      = b_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      result_d = result_q;
      flag_d   = flag_q;
      branch_d = branch_q;
`ifdef ALU_MULTICYCLE_HIRES_EN
      rhi_d    = rhi_q;
`endif
      unique case (state_q)
         IDLE: if (start) begin
            mul_d = is_mul;
            b_d   = data_b;
            if (is_mul || (is_div && data_b != '0)) begin
               state_d = CALC;
               cnt_d   = CW'(WIDTH);
               hi_d    = '0;
               lo_d    = data_a;
            end else begin
               state_d  = FINISH;
               branch_d = 1'b0;
`ifdef ALU_MULTICYCLE_HIRES_EN
               rhi_d    = '0;
`endif
               case (alu_control)
                  OP_ADDI: begin
                     result_d = add_sum[WIDTH-1:0];
                     flag_d   = add_sum[WIDTH] ? FL_OVF : FL_NONE;
                  end
                  OP_SUBI: begin
                     result_d = data_a - data_b;
                     flag_d   = (data_a < data_b) ? FL_UNF : FL_NONE;
                  end
                  OP_TYPER: begin
                     flag_d = FL_NONE;
                     case (func)
                        FN_ADD: begin
                           result_d = add_sum[WIDTH-1:0];
                           flag_d   = add_sum[WIDTH] ? FL_OVF : FL_NONE;
                        end
                        FN_SUB: begin
                           result_d = data_a - data_b;
                           flag_d   = (data_a < data_b) ? FL_UNF : FL_NONE;
                        end
                        FN_AND:  result_d = data_a & data_b;
                        FN_OR:   result_d = data_a | data_b;
                        FN_NOT:  result_d = ~data_a;
                        // Only divide-by-zero and undefined functions reach here.
                        default: begin
                           result_d = '0;
                           flag_d   = FL_EXC;
                        end
                     endcase
                  end
                  OP_ANDI: begin
                     result_d = data_a & data_b;
                     flag_d   = FL_NONE;
                  end
                  OP_ORI: begin
                     result_d = data_a | data_b;
                     flag_d   = FL_NONE;
                  end
                  OP_BRFL: begin
                     result_d = data_a;
                     branch_d = (flag_q == data_b[2:0]);
                  end
                  OP_CMP: flag_d = (data_a == data_b) ? FL_EQUAL :
                                   (data_a > data_b)  ? FL_ABOVE : FL_NONE;
                  default: begin
                     result_d = '0;
                     flag_d   = FL_EXC;
                  end
               endcase
            end
         end
         CALC: begin
            cnt_d = cnt_q - CW'(1);
            hi_d  = step_hi;
            lo_d  = step_lo;
            if (cnt_q == CW'(1)) begin
               state_d  = FINISH;
               result_d = step_lo;
               flag_d   = (mul_q && step_hi != '0) ? FL_OVF : FL_NONE;
               branch_d = 1'b0;
`ifdef ALU_MULTICYCLE_HIRES_EN
               rhi_d    = step_hi;
`endif
            end
         end
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         mul_q    <= 1'b0;
         b_q      <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         result_q <= '0;
         flag_q   <= FL_NONE;
         branch_q <= 1'b0;
`ifdef ALU_MULTICYCLE_HIRES_EN
         rhi_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         mul_q    <= mul_d;
         b_q      <= b_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         result_q <= result_d;
         flag_q   <= flag_d;
         branch_q <= branch_d;
`ifdef ALU_MULTICYCLE_HIRES_EN
         rhi_q    <= rhi_d;
`endif
      end
   end

   assign busy   = (state_q != IDLE);
   assign done   = (state_q == FINISH);
   assign result = result_q;
   assign flag   = flag_q;
   assign branch = branch_q;
`ifdef ALU_MULTICYCLE_HIRES_EN
   assign result_hi = rhi_q;
`endif

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed vector table plus hand-written sequences for mid-CALC start and mid-CALC reset (WIDTH=32).
module tb_alu_multicycle;

   logic        clock = 1'b0;
   logic        reset, start;
   logic [2:0]  alu_control;
   logic [5:0]  func;
   logic [31:0] data_a, data_b;
   logic        busy, done, branch;
   logic [31:0] result;
   logic [2:0]  flag;
`ifdef ALU_MULTICYCLE_HIRES_EN
   logic [31:0] result_hi;
`endif

   alu_multicycle #(.WIDTH(32)) dut (
      .clock(clock), .reset(reset), .start(start), .alu_control(alu_control), .func(func),
      .data_a(data_a), .data_b(data_b), .busy(busy), .done(done), .result(result), .flag(flag),
`ifdef ALU_MULTICYCLE_HIRES_EN
      .result_hi(result_hi),
`endif
      .branch(branch)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [2:0]  ctrl;
      logic [5:0]  fn;
      logic [31:0] a, b;
      int          lat;
      logic [31:0] res;
      logic [2:0]  flg;
      logic        br;
      logic [31:0] hi;
   } vec_t;

   vec_t vecs[$];
   int   n_total = 0;
   int   n_pass  = 0;

   task automatic add(input logic [2:0] c, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                      input int lat, input logic [31:0] res, input logic [2:0] flg, input logic br,
                      input logic [31:0] hi);
      vec_t v;
      v.ctrl = c; v.fn = f; v.a = a; v.b = b; v.lat = lat;
      v.res = res; v.flg = flg; v.br = br; v.hi = hi;
      vecs.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
   endtask

   task automatic start_op(input logic [2:0] c, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      alu_control = c; func = f; data_a = a; data_b = b; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int already, output int lat);
      lat = already;
      while (!done && lat < 100) begin
         @(posedge clock); #1;
         lat++;
      end
   endtask

   initial begin
      int lat, dones;
      reset = 1'b1; start = 1'b0; alu_control = '0; func = '0; data_a = '0; data_b = '0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      chk("reset busy", busy, 0);
      chk("reset done", done, 0);
      chk("reset result", result, 0);
      chk("reset flag", flag, 0);
      chk("reset branch", branch, 0);
`ifdef ALU_MULTICYCLE_HIRES_EN
      chk("reset result_hi", result_hi, 0);
`endif

      //   ctrl     func        a             b            lat res           flag    br  hi
      add(3'b000, 6'b000000, 32'hFFFFFFFF, 32'd1,        1,  32'h0,        3'b011, 0, 0);
      add(3'b001, 6'b000000, 32'd3,        32'd5,        1,  32'hFFFFFFFE, 3'b100, 0, 0);
      add(3'b000, 6'b000000, 32'd2,        32'd3,        1,  32'd5,        3'b000, 0, 0);
      add(3'b010, 6'b100000, 32'd7,        32'd8,        1,  32'd15,       3'b000, 0, 0);
      add(3'b010, 6'b100010, 32'd10,       32'd4,        1,  32'd6,        3'b000, 0, 0);
      add(3'b010, 6'b100100, 32'hF0F0,     32'hFF00,     1,  32'hF000,     3'b000, 0, 0);
      add(3'b010, 6'b100101, 32'hF0F0,     32'h0F00,     1,  32'hFFF0,     3'b000, 0, 0);
      add(3'b010, 6'b100111, 32'h0000FFFF, 32'd0,        1,  32'hFFFF0000, 3'b000, 0, 0);
      add(3'b011, 6'b000000, 32'hC,        32'hA,        1,  32'h8,        3'b000, 0, 0);
      add(3'b100, 6'b000000, 32'hC,        32'h3,        1,  32'hF,        3'b000, 0, 0);
      add(3'b010, 6'b000010, 32'h10000,    32'h10000,    33, 32'h0,        3'b011, 0, 32'h1);
      add(3'b010, 6'b000010, 32'd6,        32'd7,        33, 32'd42,       3'b000, 0, 0);
      add(3'b010, 6'b000001, 32'd100,      32'd7,        33, 32'd14,       3'b000, 0, 32'd2);
      add(3'b010, 6'b000001, 32'd5,        32'd0,        1,  32'h0,        3'b010, 0, 0);
      add(3'b010, 6'b111111, 32'd5,        32'd6,        1,  32'h0,        3'b010, 0, 0);
      add(3'b111, 6'b000000, 32'd5,        32'd6,        1,  32'h0,        3'b010, 0, 0);
      add(3'b000, 6'b000000, 32'd1,        32'd1,        1,  32'd2,        3'b000, 0, 0);
      add(3'b110, 6'b000000, 32'd5,        32'd5,        1,  32'd2,        3'b001, 0, 0);
      add(3'b101, 6'b000000, 32'h40,       32'd1,        1,  32'h40,       3'b001, 1, 0);
      add(3'b101, 6'b000000, 32'h41,       32'd5,        1,  32'h41,       3'b001, 0, 0);
      add(3'b110, 6'b000000, 32'd9,        32'd3,        1,  32'h41,       3'b101, 0, 0);
      add(3'b110, 6'b000000, 32'd3,        32'd9,        1,  32'h41,       3'b000, 0, 0);
      add(3'b010, 6'b000010, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'h1,        3'b011, 0, 32'hFFFFFFFE);
      add(3'b010, 6'b000001, 32'hFFFFFFFF, 32'd1,        33, 32'hFFFFFFFF, 3'b000, 0, 0);
      add(3'b010, 6'b000010, 32'd5,        32'd0,        33, 32'h0,        3'b000, 0, 0);

      foreach (vecs[i]) begin
         start_op(vecs[i].ctrl, vecs[i].fn, vecs[i].a, vecs[i].b);
         data_a = 32'hDEADBEEF; data_b = 32'h12345678;
         wait_done(1, lat);
         chk($sformatf("v%0d latency", i), lat, vecs[i].lat);
         chk($sformatf("v%0d result", i), result, vecs[i].res);
         chk($sformatf("v%0d flag", i), flag, vecs[i].flg);
         chk($sformatf("v%0d branch", i), branch, vecs[i].br);
`ifdef ALU_MULTICYCLE_HIRES_EN
         chk($sformatf("v%0d result_hi", i), result_hi, vecs[i].hi);
`endif
         @(posedge clock); #1;
         chk($sformatf("v%0d done pulse width", i), done, 0);
      end

      // start pulsed mid-CALC with different operands must be ignored
      start_op(3'b010, 6'b000010, 32'h10000, 32'h10000);
      repeat (4) begin @(posedge clock); #1; end
      alu_control = 3'b000; func = 6'b000000; data_a = 32'd1; data_b = 32'd1; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      chk("midcalc busy", busy, 1);
      wait_done(6, lat);
      chk("midcalc latency", lat, 33);
      chk("midcalc result", result, 0);
      chk("midcalc flag", flag, 3'b011);
      @(posedge clock); #1;
      chk("midcalc back idle", busy, 0);

      start_op(3'b000, 6'b000000, 32'd4, 32'd4);
      wait_done(1, lat);
      chk("pre-reset add result", result, 8);

      // reset at CALC cycle 10 of a MUL aborts it silently
      @(posedge clock); #1;
      start_op(3'b010, 6'b000010, 32'h10000, 32'h10000);
      repeat (9) begin @(posedge clock); #1; end
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      chk("abort busy", busy, 0);
      chk("abort done", done, 0);
      chk("abort result", result, 0);
      chk("abort flag", flag, 0);
      chk("abort branch", branch, 0);
      dones = 0;
      repeat (40) begin
         @(posedge clock); #1;
         if (done) dones++;
      end
      chk("abort no done", dones, 0);
      start_op(3'b010, 6'b100000, 32'd2, 32'd3);
      wait_done(1, lat);
      chk("post-reset add latency", lat, 1);
      chk("post-reset add result", result, 5);
      chk("post-reset add flag", flag, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
